blink_meter: RTL and testbench

Receive-side companion to the LED blink counter. Samples an asynchronous square wave (a blink line), synchronizes it and measures the period between successive rising edges in clk cycles. Each completed measurement is offered on a valid/ack interface. Loss of signal is flagged when no edge arrives within the counter range.

---
 rtl/blink_meter_pkg.sv | 9 +
 rtl/blink_meter_sync_rise_detect.sv | 23 ++
 rtl/blink_meter.sv | 60 ++++++
 tb/tb_blink_meter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/blink_meter_pkg.sv
// blink_meter_pkg: shared state encoding and counter limits for the blink period meter.
package blink_meter_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_MEASURE = 1'b1} state_t;
    localparam int DEF_WIDTH = 8;
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction
    localparam int CNT_MAX = cnt_max(DEF_WIDTH);
endpackage

// File: rtl/blink_meter_sync_rise_detect.sv
// sync_rise_detect: multi-flop synchronizer for an async level plus rising-edge detect.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sig_s,
    output logic rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic r_sig_d;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_sync  <= '0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_sig_d <= r_sync[SYNC_STAGES-1];
        end
    assign sig_s = r_sync[SYNC_STAGES-1];
    assign rise  = sig_s & ~r_sig_d;
endmodule

// File: rtl/blink_meter.sv
// blink_meter: measures rise-to-rise period of an async blink line, offers it on valid/ack,
// flags overrun of unacknowledged results and loss of signal.
module blink_meter
    import blink_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ack,
    output logic             overrun,
    output logic             timeout,
    output logic             locked
);
    localparam logic [WIDTH-1:0] CNT_TOP = WIDTH'(cnt_max(WIDTH));
    state_t r_state, w_state_nx;
    logic [WIDTH-1:0] r_cnt, w_cnt_nx, r_period;
    logic r_valid, r_overrun, r_timeout;
    logic w_sig_s, w_rise, w_edge, w_cap, w_to;
    sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_in(sig_in),
        .sig_s (w_sig_s),
        .rise  (w_rise)
    );
    assign w_edge = w_rise & w_sig_s;
    always_comb begin
        w_cap      = (r_state == ST_MEASURE) && w_edge;
        w_to       = (r_state == ST_MEASURE) && !w_edge && (r_cnt == CNT_TOP);
        w_cnt_nx   = w_edge ? WIDTH'(1) : (r_state == ST_IDLE || w_to) ? '0 : r_cnt + 1'b1;
        w_state_nx = w_edge ? ST_MEASURE : w_to ? ST_IDLE : r_state;
    end
    // A capture always wins over an ack of the previous result; overrun only survives an unacked replace.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_timeout <= w_to;
            if (w_cap) r_period <= r_cnt;
            r_valid   <= w_cap | (r_valid & ~period_ack);
            r_overrun <= w_cap ? (r_valid & ~period_ack) : (r_overrun & ~(r_valid & period_ack));
        end
    assign period       = r_period;
    assign period_valid = r_valid;
    assign overrun      = r_overrun;
    assign timeout      = r_timeout;
    assign locked       = (r_state == ST_MEASURE);
endmodule

// File: tb/tb_blink_meter.sv
// tb_blink_meter: directed square-wave stimulus with a queue scoreboard for acked periods
// plus directed checks of lock, timeout, overrun, simultaneous ack and async reset.
module tb_blink_meter;
    import blink_meter_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sig_in = 1'b0;
    logic       man_ack = 1'b0;
    logic       auto_ack = 1'b0;
    logic       ack_en = 1'b0;
    logic       period_ack;
    logic [7:0] period;
    logic       period_valid, overrun, timeout, locked;
    int n_tests = 0, n_fail = 0, cyc = 0, c0 = 0;
    int to_cnt = 0, to_cyc = 0, to_period = 0, to_valid = 0, to_locked = 0;
    int exp_q[$];
    assign period_ack = man_ack | auto_ack;
    blink_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .sig_in      (sig_in),
        .period      (period),
        .period_valid(period_valid),
        .period_ack  (period_ack),
        .overrun     (overrun),
        .timeout     (timeout),
        .locked      (locked)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    // One rise now, held high for hi cycles; the next call's rise lands exactly gap cycles later.
    task automatic edge_at(input int gap, input int hi);
        sig_in = 1'b1;
        tick(hi);
        sig_in = 1'b0;
        tick(gap - hi);
    endtask
    always @(negedge clk) begin
        if (timeout) begin
            to_cnt++;
            to_cyc    = cyc;
            to_period = int'(period);
            to_valid  = int'(period_valid);
            to_locked = int'(locked);
        end
        if (ack_en && period_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_period: got %0d expected none", period);
            end else begin
                check("sb_period", int'(period), exp_q.pop_front());
            end
            check("sb_overrun", int'(overrun), 0);
        end
        auto_ack = ack_en && period_valid;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        tick(2);
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_locked", int'(locked), 0);
        rst = 1'b1;
        tick(3);
        check("idle_locked", int'(locked), 0);
        ack_en = 1'b1;
        edge_at(10, 5);
        check("first_locked", int'(locked), 1);
        check("first_valid", int'(period_valid), 0);
        repeat (4) begin
            exp_q.push_back(10);
            edge_at(10, 5);
        end
        exp_q.push_back(10);
        edge_at(CNT_MAX, 5);
        exp_q.push_back(CNT_MAX);
        c0 = cyc;
        edge_at(CNT_MAX + 1, 5);
        check("no_timeout_255", to_cnt, 0);
        edge_at(20, 5);
        check("timeout_cnt", to_cnt, 1);
        check("timeout_cyc", to_cyc, c0 + 258);
        check("timeout_period", to_period, CNT_MAX);
        check("timeout_locked", to_locked, 0);
        check("timeout_valid", to_valid, 0);
        exp_q.push_back(20);
        edge_at(6, 3);
        ack_en = 1'b0;
        edge_at(6, 3);
        check("ovr1_period", int'(period), 6);
        check("ovr1_valid", int'(period_valid), 1);
        check("ovr1_overrun", int'(overrun), 0);
        edge_at(6, 3);
        check("ovr2_period", int'(period), 6);
        check("ovr2_valid", int'(period_valid), 1);
        check("ovr2_overrun", int'(overrun), 1);
        edge_at(6, 3);
        check("ovr3_overrun", int'(overrun), 1);
        check("ovr3_valid", int'(period_valid), 1);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check("ack_valid", int'(period_valid), 0);
        check("ack_overrun", int'(overrun), 0);
        edge_at(6, 3);
        check("p7_period", int'(period), 7);
        check("p7_overrun", int'(overrun), 0);
        edge_at(9, 3);
        check("p6_period", int'(period), 6);
        check("p6_overrun", int'(overrun), 1);
        sig_in = 1'b1;
        tick(2);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        check("simul_period", int'(period), 9);
        check("simul_valid", int'(period_valid), 1);
        check("simul_overrun", int'(overrun), 0);
        sig_in = 1'b0;
        tick(3);
        man_ack = 1'b1;
        tick(1);
        man_ack = 1'b0;
        tick(2);
        check("pre_rst_locked", int'(locked), 1);
        check("pre_rst_cnt7_period", int'(period), 9);
        #2 rst = 1'b0;
        #1;
        check("arst_period", int'(period), 0);
        check("arst_valid", int'(period_valid), 0);
        check("arst_overrun", int'(overrun), 0);
        check("arst_timeout", int'(timeout), 0);
        check("arst_locked", int'(locked), 0);
        tick(1);
        rst = 1'b1;
        ack_en = 1'b1;
        edge_at(8, 4);
        check("relock_locked", int'(locked), 1);
        check("relock_valid", int'(period_valid), 0);
        check("relock_period", int'(period), 0);
        exp_q.push_back(8);
        repeat (5) exp_q.push_back(2);
        repeat (6) edge_at(2, 1);
        tick(10);
        check("queue_empty", exp_q.size(), 0);
        check("end_overrun", int'(overrun), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
